// File: rtl/cube_root_arbiter.sv
// cube_root_arbiter
//   Round-robin front end for a single cube_root digit-by-digit core. One operand
//   is accepted at a time. The core is started by pulsing its active-high reset
//   while the operand is held. Its result is sampled a fixed LATENCY cycles later
//   and returned on one tagged response channel that supports backpressure.
//
// Ports
//   clk            rising-edge system clock
//   reset          synchronous, active-low reset
//   req_valid      per-requester operand valid
//   req_data       operands, requester i at [32*i+31:32*i]
//   req_ready      one-hot grant, nonzero only in IDLE
//   resp_valid     result available
//   resp_ready     response consumer accept
//   resp_id        index of the requester owning resp_data
//   resp_data      integer cube root, zero-extended
//   busy           high whenever the FSM is not in IDLE
//   cr_reset       active-high reset/start pulse to the core
//   cr_number_in   operand to the core (last accepted operand)
//   cr_number_out  core result
module cube_root_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned LATENCY = 40,
   parameter int unsigned ID_W    = $clog2(N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      req_valid,
   input  logic [32*N-1:0]   req_data,
   output logic [N-1:0]      req_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [ID_W-1:0]   resp_id,
   output logic [31:0]       resp_data,
   output logic              busy,
   output logic              cr_reset,
   output logic [31:0]       cr_number_in,
   input  logic [31:0]       cr_number_out
);

   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StRun,
      StResp
   } state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   tag_q, tag_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       num_q, num_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [ID_W-1:0]   rid_q, rid_d;

   logic              gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   int unsigned       idx;
   logic              handshake;

   // Rotating-priority search: first valid requester at or above ptr, modulo N.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr_q) + k) % N;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(idx);
         end
      end
   end

   // Grant is combinational and gated by reset so nothing transfers while held in reset.
   assign handshake = (state_q == StIdle) && reset && gnt_found;
   assign req_ready = handshake ? (N'(1) << gnt_idx) : '0;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      tag_d   = tag_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      rdata_d = rdata_q;
      rid_d   = rid_q;
      unique case (state_q)
         StIdle: begin
            if (handshake) begin
               num_d   = req_data[32*gnt_idx +: 32];
               tag_d   = gnt_idx;
               ptr_d   = (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
               state_d = StLoad;
            end
         end
         StLoad: begin
            cnt_d   = '0;
            state_d = StRun;
         end
         StRun: begin
            cnt_d = cnt_q + 1'b1;
            // cnt_q counts completed RUN cycles; this is the LATENCY-th one.
            if (cnt_q == CNT_W'(LATENCY - 1)) begin
               rdata_d = cr_number_out;
               rid_d   = tag_q;
               state_d = StResp;
            end
         end
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         tag_q   <= '0;
         cnt_q   <= '0;
         num_q   <= '0;
         rdata_q <= '0;
         rid_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         tag_q   <= tag_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         rdata_q <= rdata_d;
         rid_q   <= rid_d;
      end
   end

   assign resp_valid   = (state_q == StResp);
   assign resp_id      = rid_q;
   assign resp_data    = rdata_q;
   assign busy         = (state_q != StIdle);
   // Holding the core in reset while the block is reset keeps it cleared.
   assign cr_reset     = !reset || (state_q == StLoad);
   assign cr_number_in = num_q;

endmodule

// File: tb/tb_cube_root_arbiter.sv
// Testbench for cube_root_arbiter with a behavioural cube_root core model.
module tb_cube_root_arbiter;

   localparam int N   = 4;
   localparam int LAT = 40;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req_valid;
   logic [32*N-1:0]  req_data;
   logic [N-1:0]     req_ready;
   logic             resp_valid;
   logic             resp_ready;
   logic [IDW-1:0]   resp_id;
   logic [31:0]      resp_data;
   logic             busy;
   logic             cr_reset;
   logic [31:0]      cr_number_in;
   logic [31:0]      cr_number_out;

   always #5 clk = ~clk;

   cube_root_arbiter #(
      .N       (N),
      .LATENCY (LAT),
      .ID_W    (IDW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_id       (resp_id),
      .resp_data     (resp_data),
      .busy          (busy),
      .cr_reset      (cr_reset),
      .cr_number_in  (cr_number_in),
      .cr_number_out (cr_number_out)
   );

   function automatic logic [31:0] cbrt(input logic [31:0] x);
      logic [31:0] r;
      logic [63:0] t;
      r = '0;
      for (int b = 10; b >= 0; b--) begin
         t = {32'd0, r | (32'd1 << b)};
         if (t * t * t <= {32'd0, x}) r = r | (32'd1 << b);
      end
      return r;
   endfunction

   // Core model: result only valid once enough cycles have elapsed since the start pulse.
   int core_cnt;
   always @(posedge clk) begin
      if (cr_reset) core_cnt <= 0;
      else if (core_cnt < LAT) core_cnt <= core_cnt + 1;
   end
   assign cr_number_out = (core_cnt >= LAT - 1) ? cbrt(cr_number_in) : 32'hFFFF_FFFF;

   int n_chk = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [31:0]    data;
   } exp_t;

   exp_t         q[$];
   exp_t         e;
   int           grant_log[$];
   int           cyc = 0;
   int           model_ptr = 0;
   int           hs_edge = 0;
   int           pulse_cnt = 0;
   int           n_resp = 0;
   int           m_id;
   int           m_idx;
   logic         rv_prev = 1'b0;
   logic [N-1:0] gnt_seen = '0;
   logic [N-1:0] sticky = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor/scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         check_eq("rst_req_ready", req_ready, 0);
         check_eq("rst_cr_reset", cr_reset, 1);
         q.delete();
         model_ptr = 0;
         rv_prev   = 1'b0;
      end else begin
         check_eq("gnt_onehot", $onehot0(req_ready), 1);
         check_eq("gnt_idle_only", busy && (req_ready != 0), 0);
         if (cr_reset) pulse_cnt++;
         if (resp_valid && !rv_prev) begin
            check_eq("latency", cyc - hs_edge, LAT + 1);
            check_eq("cr_pulse", pulse_cnt, 1);
         end
         rv_prev = resp_valid;
         if (resp_valid) begin
            check_eq("resp_busy", busy, 1);
            if (q.size() == 0) begin
               check_eq("unexpected_resp", resp_valid, 0);
            end else begin
               check_eq("resp_id", resp_id, q[0].id);
               check_eq("resp_data", resp_data, q[0].data);
               if (resp_ready) begin
                  e = q.pop_front();
                  n_resp++;
               end
            end
         end
         if ((req_valid & req_ready) != 0) begin
            m_id = -1;
            for (int k = 0; k < N; k++) begin
               m_idx = (model_ptr + k) % N;
               if (m_id < 0 && req_valid[m_idx]) m_id = m_idx;
            end
            check_eq("grant", req_ready, 1 << m_id);
            e.id   = IDW'(m_id);
            e.data = cbrt(req_data[32*m_id +: 32]);
            q.push_back(e);
            grant_log.push_back(m_id);
            model_ptr    = (m_id + 1) % N;
            hs_edge      = cyc + 1;
            pulse_cnt    = 0;
            gnt_seen[m_id] = 1'b1;
         end
      end
   end

   // Advance one edge; granted non-sticky requesters drop their request.
   task automatic step();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(gnt_seen & ~sticky);
      gnt_seen  = '0;
   endtask

   task automatic req(input int i, input logic [31:0] d);
      req_data[32*i +: 32] = d;
      req_valid[i]         = 1'b1;
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int i;
      i = 0;
      while ((req_valid != 0 || q.size() != 0) && i < budget) begin
         step();
         i++;
      end
      check_eq({tag, "_drain"}, i < budget, 1);
   endtask

   int base;
   int w;

   initial begin
      reset      = 1'b0;
      req_valid  = '0;
      req_data   = '0;
      resp_ready = 1'b1;
      step();
      step();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_resp_valid", resp_valid, 0);
      check_eq("rst_resp_id", resp_id, 0);
      check_eq("rst_resp_data", resp_data, 0);
      check_eq("rst_cr_number_in", cr_number_in, 0);
      reset = 1'b1;
      step();

      // Single request
      grant_log.delete();
      base = n_resp;
      req(2, 27);
      wait_drain(200, "single");
      check_eq("single_n", n_resp - base, 1);
      check_eq("single_cr_in", cr_number_in, 27);

      // Contention from ptr=0
      reset = 1'b0;
      step();
      reset = 1'b1;
      grant_log.delete();
      base = n_resp;
      req(0, 8);
      req(1, 27);
      req(2, 64);
      req(3, 125);
      wait_drain(400, "contend");
      check_eq("contend_n", n_resp - base, 4);
      check_eq("contend_log_n", grant_log.size(), 4);
      for (int k = 0; k < 4 && k < grant_log.size(); k++) check_eq("contend_order", grant_log[k], k);

      // Fairness with two continuously asserted requesters
      grant_log.delete();
      base   = n_resp;
      sticky = 4'b0011;
      req(0, 1000);
      req(1, 0);
      w = 0;
      while (n_resp < base + 4 && w < 600) begin
         step();
         w++;
      end
      check_eq("fair_wait", w < 600, 1);
      sticky    = '0;
      req_valid = '0;
      wait_drain(200, "fair");
      check_eq("fair_log_n", grant_log.size(), 4);
      for (int k = 0; k < 4 && k < grant_log.size(); k++) check_eq("fair_order", grant_log[k], k % 2);

      // Backpressure
      grant_log.delete();
      base       = n_resp;
      resp_ready = 1'b0;
      req(1, 64);
      w = 0;
      while (!resp_valid && w < 100) begin
         step();
         w++;
      end
      check_eq("bp_wait", w < 100, 1);
      req(3, 343);
      for (int k = 0; k < 15; k++) begin
         step();
         check_eq("bp_valid", resp_valid, 1);
         check_eq("bp_id", resp_id, 1);
         check_eq("bp_data", resp_data, 4);
         check_eq("bp_req_ready", req_ready, 0);
      end
      check_eq("bp_no_grant", grant_log.size(), 1);
      resp_ready = 1'b1;
      wait_drain(300, "bp");
      check_eq("bp_n", n_resp - base, 2);

      // Reset in the middle of RUN
      req(0, 1000);
      w = 0;
      while (q.size() == 0 && w < 50) begin
         step();
         w++;
      end
      check_eq("mid_wait", w < 50, 1);
      for (int k = 0; k < 11; k++) step();
      check_eq("mid_busy_run", busy, 1);
      reset = 1'b0;
      step();
      check_eq("mid_busy", busy, 0);
      check_eq("mid_resp_valid", resp_valid, 0);
      check_eq("mid_cr_in", cr_number_in, 0);
      reset = 1'b1;
      grant_log.delete();
      base = n_resp;
      req(1, 1);
      req(3, 4096);
      wait_drain(300, "mid");
      check_eq("mid_n", n_resp - base, 2);
      check_eq("mid_log_n", grant_log.size(), 2);
      if (grant_log.size() > 0) check_eq("mid_first", grant_log[0], 1);

      // Random traffic
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
               if ($urandom_range(0, 3) == 0) req(i, $urandom_range(0, 1000));
               else req(i, $urandom);
            end
         end
         resp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      resp_ready = 1'b1;
      wait_drain(3000, "rand");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
